// File: rtl/wave_gen_dds.sv
// wave_gen_dds: phase-accumulator waveform generator (OFF/SAW/TRI/SQR)
// with programmable step, amplitude and square duty.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - advance enable; low freezes phase and pipeline
//   cmd_valid/ready - command handshake; cmd_mode/step/amp/duty payload
//   wave_out        - scaled sample, two enabled cycles behind the phase
//   wave_valid      - en delayed through the two pipeline stages
//   wrap            - one-cycle pulse when the phase accumulator carries out
module wave_gen_dds #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [PHASE_W-1:0] cmd_step,
    input  logic [DATA_W-1:0]  cmd_amp,
    input  logic [DATA_W-1:0]  cmd_duty,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        M_OFF = 2'd0,
        M_SAW = 2'd1,
        M_TRI = 2'd2,
        M_SQR = 2'd3
    } mode_e;

    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};

    // active settings
    mode_e               mode_q,  mode_d;
    logic [PHASE_W-1:0]  step_q,  step_d;
    logic [DATA_W-1:0]   amp_q,   amp_d;
    logic [DATA_W-1:0]   duty_q,  duty_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;

    // pending command, applied at the next period boundary
    logic                pend_q,  pend_d;
    mode_e               pmode_q, pmode_d;
    logic [PHASE_W-1:0]  pstep_q, pstep_d;
    logic [DATA_W-1:0]   pamp_q,  pamp_d;
    logic [DATA_W-1:0]   pduty_q, pduty_d;

    // pipeline
    logic [DATA_W-1:0]   raw_q,   raw_d;
    logic [DATA_W-1:0]   ramp_q;
    logic [DATA_W-1:0]   wave_q,  wave_d;
    logic                v1_q,    v2_q;
    logic                wrap_q;

    logic [PHASE_W:0]    sum;
    logic                adv;
    logic                carry;
    logic                accept;
    logic                apply;

    logic [DATA_W-1:0]   p;
    logic [DATA_W-1:0]   tri_up;
    logic [DATA_W-1:0]   tri_dn;
    logic [DATA_W:0]     amp_p1;
    logic [2*DATA_W:0]   prod;
    logic                unused_prod;

    assign cmd_ready = ~pend_q;

    always_comb begin
        sum    = {1'b0, phase_q} + {1'b0, step_q};
        adv    = en && (mode_q != M_OFF);
        carry  = adv && sum[PHASE_W];
        accept = cmd_valid && !pend_q;
        // with step=0 the period never ends, so apply right away
        apply  = pend_q && (carry || (step_q == '0));

        mode_d  = mode_q;
        step_d  = step_q;
        amp_d   = amp_q;
        duty_d  = duty_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        pmode_d = pmode_q;
        pstep_d = pstep_q;
        pamp_d  = pamp_q;
        pduty_d = pduty_q;

        if (adv) begin
            phase_d = sum[PHASE_W-1:0];
        end

        if (apply) begin
            mode_d = pmode_q;
            step_d = pstep_q;
            amp_d  = pamp_q;
            duty_d = pduty_q;
            pend_d = 1'b0;
            if (pmode_q == M_OFF) begin
                phase_d = '0;
            end
        end

        // accept and apply are exclusive: accept needs pend_q low
        if (accept) begin
            if (mode_q == M_OFF) begin
                mode_d  = mode_e'(cmd_mode);
                step_d  = cmd_step;
                amp_d   = cmd_amp;
                duty_d  = cmd_duty;
                phase_d = '0;
            end else begin
                pend_d  = 1'b1;
                pmode_d = mode_e'(cmd_mode);
                pstep_d = cmd_step;
                pamp_d  = cmd_amp;
                pduty_d = cmd_duty;
            end
        end
    end

    // stage 1: shape the top phase bits into a raw sample
    always_comb begin
        p      = phase_q[PHASE_W-1 -: DATA_W];
        tri_up = {p[DATA_W-2:0], 1'b0};
        // odd LSB on the way down keeps the ramp symmetric: peak 2^W-2
        tri_dn = ~{p[DATA_W-2:0], 1'b1};
        raw_d  = '0;
        unique case (mode_q)
            M_SAW:   raw_d = p;
            M_TRI:   raw_d = p[DATA_W-1] ? tri_dn : tri_up;
            M_SQR:   raw_d = (p < duty_q) ? ONES : '0;
            default: raw_d = '0;
        endcase
    end

    // stage 2: scale by (amp+1)/2^W; amp travels with its sample
    always_comb begin
        amp_p1 = {1'b0, ramp_q} + {{DATA_W{1'b0}}, 1'b1};
        prod   = {{(DATA_W+1){1'b0}}, raw_q} * {{DATA_W{1'b0}}, amp_p1};
        wave_d = prod[2*DATA_W-1:DATA_W];
    end

    assign unused_prod = ^{prod[2*DATA_W], prod[DATA_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= M_OFF;
            step_q  <= '0;
            amp_q   <= ONES;
            duty_q  <= HALF;
            phase_q <= '0;
            pend_q  <= 1'b0;
            pmode_q <= M_OFF;
            pstep_q <= '0;
            pamp_q  <= ONES;
            pduty_q <= HALF;
            raw_q   <= '0;
            ramp_q  <= ONES;
            wave_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            amp_q   <= amp_d;
            duty_q  <= duty_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            pmode_q <= pmode_d;
            pstep_q <= pstep_d;
            pamp_q  <= pamp_d;
            pduty_q <= pduty_d;
            if (en) begin
                raw_q  <= raw_d;
                ramp_q <= amp_q;
                wave_q <= wave_d;
            end
            v1_q   <= en;
            v2_q   <= v1_q;
            wrap_q <= carry;
        end
    end

    assign wave_out   = wave_q;
    assign wave_valid = v2_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_wave_gen_dds.sv
// tb_wave_gen_dds: scoreboard bench for wave_gen_dds (DATA_W=8, PHASE_W=16).
// A behavioural model queues expected samples; a negedge monitor pops them.
module tb_wave_gen_dds;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'd0;
    logic [15:0] cmd_step = 16'd0;
    logic [7:0]  cmd_amp = 8'd0;
    logic [7:0]  cmd_duty = 8'd0;
    logic [7:0]  wave_out;
    logic        wave_valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    wave_gen_dds #(.DATA_W(8), .PHASE_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_step(cmd_step),
        .cmd_amp(cmd_amp), .cmd_duty(cmd_duty),
        .wave_out(wave_out), .wave_valid(wave_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // reference model state
    int m_mode = 0, m_step = 0, m_amp = 255, m_duty = 128, m_phase = 0;
    int p_mode = 0, p_step = 0, p_amp = 255, p_duty = 128;
    bit m_pend = 1'b0;
    bit exp_wrap = 1'b0;
    bit chk = 1'b0;
    logic [7:0] sb[$];

    function automatic int model_sample(int mode, int phase, int amp, int duty);
        int pi;
        int raw;
        pi = phase / 256;
        case (mode)
            1: raw = pi;
            2: raw = (pi < 128) ? 2 * pi : 2 * (255 - pi);
            3: raw = (pi < duty) ? 255 : 0;
            default: raw = 0;
        endcase
        return (raw * (amp + 1)) / 256;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_step = 0; m_amp = 255; m_duty = 128;
            m_phase = 0; m_pend = 1'b0; exp_wrap = 1'b0; chk = 1'b0;
            sb.delete();
        end else begin
            int sum;
            int nph;
            bit acc;
            bit adv;
            bit cy;
            acc = cmd_valid && !m_pend;
            adv = en && (m_mode != 0);
            sum = m_phase + m_step;
            cy  = adv && (sum >= 65536);
            exp_wrap = cy;
            if (en) begin
                sb.push_back(8'(model_sample(m_mode, m_phase, m_amp, m_duty)));
                chk = (sb.size() >= 2);
            end else begin
                chk = 1'b0;
            end
            nph = adv ? (sum % 65536) : m_phase;
            if (m_pend && (cy || m_step == 0)) begin
                m_mode = p_mode; m_step = p_step;
                m_amp = p_amp; m_duty = p_duty;
                m_pend = 1'b0;
                if (p_mode == 0) nph = 0;
            end
            if (acc) begin
                if (m_mode == 0) begin
                    m_mode = int'(cmd_mode); m_step = int'(cmd_step);
                    m_amp = int'(cmd_amp); m_duty = int'(cmd_duty);
                    nph = 0;
                end else begin
                    m_pend = 1'b1;
                    p_mode = int'(cmd_mode); p_step = int'(cmd_step);
                    p_amp = int'(cmd_amp); p_duty = int'(cmd_duty);
                end
            end
            m_phase = nph;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (wrap !== exp_wrap) begin
                errors++;
                $display("FAIL sb_wrap t=%0t got %b exp %b", $time, wrap, exp_wrap);
            end
            checks++;
            if (cmd_ready !== !m_pend) begin
                errors++;
                $display("FAIL sb_ready t=%0t got %b exp %b", $time, cmd_ready, !m_pend);
            end
            if (chk) begin
                logic [7:0] e;
                e = sb.pop_front();
                chk = 1'b0;
                checks++;
                if (wave_out !== e) begin
                    errors++;
                    $display("FAIL sb_wave t=%0t got %0d exp %0d", $time, wave_out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [1:0] md, input logic [15:0] st,
                            input logic [7:0] am, input logic [7:0] du,
                            output bit ok);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_mode = md; cmd_step = st; cmd_amp = am; cmd_duty = du;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (cmd_ready === 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (cmd_ready === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wave_out !== 8'd0) begin
            errors++; $display("FAIL reset_wave got %0d exp 0", wave_out);
        end
        checks++;
        if (wave_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", wave_valid);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errors++; $display("FAIL reset_wrap got %b exp 0", wrap);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_saw;
        bit ok;
        int w = 0, first = -1, gap = 0, rlow = 0;
        en = 1'b1;
        send_cmd(2'd1, 16'h0100, 8'hFF, 8'h80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL saw_accept got timeout exp ready"); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wave_out !== 8'd0 || wave_valid !== 1'b1) begin
            errors++;
            $display("FAIL saw_first got %0d/%b exp 0/1", wave_out, wave_valid);
        end
        @(negedge clk);
        checks++;
        if (wave_out !== 8'd1) begin
            errors++; $display("FAIL saw_second got %0d exp 1", wave_out);
        end
        for (int i = 0; i < 520; i++) begin
            @(negedge clk);
            if (wrap === 1'b1) begin
                if (w == 0) first = i;
                else gap = i - first;
                w++;
            end
            if (cmd_ready !== 1'b1) rlow++;
        end
        checks++;
        if (w != 2) begin errors++; $display("FAIL saw_wraps got %0d exp 2", w); end
        checks++;
        if (gap != 256) begin errors++; $display("FAIL saw_period got %0d exp 256", gap); end
        checks++;
        if (rlow != 0) begin errors++; $display("FAIL saw_ready_low got %0d exp 0", rlow); end
    endtask

    task automatic test_switch;
        bit ok;
        int n = 0, rhi = 0, mx = 0, mn = 255;
        send_cmd(2'd2, 16'h0200, 8'hFF, 8'h80, ok);
        checks++;
        if (!ok || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL sw_pending got ready=%b exp 0", cmd_ready);
        end
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (wrap === 1'b1) break;
            if (cmd_ready !== 1'b0) rhi++;
        end
        checks++;
        if (wrap !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_apply got wrap=%b ready=%b exp 1/1", wrap, cmd_ready);
        end
        checks++;
        if (rhi != 0) begin errors++; $display("FAIL sw_ready_hi got %0d exp 0", rhi); end
        @(negedge clk);
        checks++;
        if (wave_out !== 8'd255) begin
            errors++; $display("FAIL sw_saw_top got %0d exp 255", wave_out);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (int'(wave_out) > mx) mx = int'(wave_out);
            if (int'(wave_out) < mn) mn = int'(wave_out);
        end
        checks++;
        if (mx != 254 || mn != 0) begin
            errors++; $display("FAIL tri_range got %0d..%0d exp 0..254", mn, mx);
        end
    endtask

    task automatic test_sqr;
        bit ok;
        int hi = 0, lo = 0;
        send_cmd(2'd3, 16'h0100, 8'hFF, 8'h40, ok);
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sqr_apply got timeout exp ready"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (wave_out === 8'hFF) hi++;
            if (wave_out === 8'h00) lo++;
        end
        checks++;
        if (hi != 64 || lo != 192) begin
            errors++; $display("FAIL sqr_duty40 got hi=%0d lo=%0d exp 64/192", hi, lo);
        end
        send_cmd(2'd3, 16'h0100, 8'hFF, 8'h00, ok);
        wait_ready(ok);
        repeat (3) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (wave_out !== 8'h00) hi++;
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL sqr_duty0 got %0d nonzero exp 0", hi); end
    endtask

    task automatic test_amp;
        bit ok;
        int mx = 0;
        send_cmd(2'd1, 16'h0100, 8'h7F, 8'h80, ok);
        wait_ready(ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (int'(wave_out) > mx) mx = int'(wave_out);
        end
        checks++;
        if (mx != 127) begin errors++; $display("FAIL amp7f_max got %0d exp 127", mx); end
        send_cmd(2'd1, 16'h0100, 8'h00, 8'h80, ok);
        wait_ready(ok);
        repeat (3) @(negedge clk);
        mx = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (int'(wave_out) > mx) mx = int'(wave_out);
        end
        checks++;
        if (mx != 0) begin errors++; $display("FAIL amp0_max got %0d exp 0", mx); end
    endtask

    task automatic test_en_toggle;
        bit ok;
        logic [7:0] last;
        logic [7:0] nxt;
        int moved = 0, wr = 0;
        send_cmd(2'd1, 16'h0100, 8'hFF, 8'h80, ok);
        wait_ready(ok);
        repeat (20) @(negedge clk);
        last = wave_out;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wave_out !== last) moved++;
            if (wrap !== 1'b0) wr++;
            if (i == 0) begin
                checks++;
                if (wave_valid !== 1'b1) begin
                    errors++; $display("FAIL en_valid1 got %b exp 1", wave_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if (wave_valid !== 1'b0) begin
                    errors++; $display("FAIL en_valid2 got %b exp 0", wave_valid);
                end
            end
        end
        checks++;
        if (moved != 0) begin errors++; $display("FAIL en_frozen got %0d moves exp 0", moved); end
        checks++;
        if (wr != 0) begin errors++; $display("FAIL en_wrap got %0d exp 0", wr); end
        en = 1'b1;
        nxt = last + 8'd1;
        @(negedge clk);
        checks++;
        if (wave_out !== nxt) begin
            errors++; $display("FAIL en_resume got %0d exp %0d", wave_out, nxt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wave_valid !== 1'b1) begin
            errors++; $display("FAIL en_revalid got %b exp 1", wave_valid);
        end
    endtask

    task automatic test_stuck;
        bit ok;
        send_cmd(2'd1, 16'h0000, 8'hFF, 8'h80, ok);
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stuck_saw0 got timeout exp ready"); end
        repeat (4) @(negedge clk);
        send_cmd(2'd2, 16'h0200, 8'hFF, 8'h80, ok);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL stuck_pend got %b exp 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL stuck_apply got %b exp 1", cmd_ready);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int nz = 0, wr = 0;
        send_cmd(2'd3, 16'h0100, 8'hFF, 8'h40, ok);
        checks++;
        if (cmd_ready !== 1'b0 || wave_out === 8'd0) begin
            errors++;
            $display("FAIL mid_pre got ready=%b wave=%0d exp 0/nonzero", cmd_ready, wave_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wave_out !== 8'd0 || cmd_ready !== 1'b1 || wave_valid !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got wave=%0d rdy=%b vld=%b wrap=%b exp 0/1/0/0",
                     wave_out, cmd_ready, wave_valid, wrap);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wave_out !== 8'd0) nz++;
            if (wrap !== 1'b0) wr++;
        end
        checks++;
        if (nz != 0 || wr != 0) begin
            errors++; $display("FAIL mid_off got nz=%0d wraps=%0d exp 0/0", nz, wr);
        end
    endtask

    initial begin
        test_reset;
        test_saw;
        test_switch;
        test_sqr;
        test_amp;
        test_en_toggle;
        test_stuck;
        test_reset_mid;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
